// File: rtl/junction_pkg.sv
// Shared definitions for the junction phase scheduler.
// Holds the phase encodings, the default timing constants and the helper
// that sizes the lane-index bus from the lane count.
package junction_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_ALL_RED = 2'd0;
  localparam phase_t PH_GREEN   = 2'd1;
  localparam phase_t PH_ORANGE  = 2'd2;

  localparam int DEF_NUM_LANES = 4;
  localparam int DEF_MIN_GREEN = 10;
  localparam int DEF_MAX_GREEN = 60;
  localparam int DEF_AMBER_T   = 4;
  localparam int DEF_ALL_RED_T = 2;

  // Width of a lane index; never narrower than one bit.
  function automatic int lane_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/junction_phase_scheduler_if.sv
// Signal bundle between the junction scheduler and its environment.
// master: drives tick/traffic and observes the lights (environment side).
// slave : consumes tick/traffic and drives the lights (scheduler side).
//   tick        - one-cycle 1 s strobe
//   traffic     - per-lane demand, level-sensitive
//   green       - one-hot green or zero
//   orange      - one-hot orange or zero
//   red         - complement of (green | orange)
//   active_lane - lane currently or most recently granted
//   phase       - 0 all-red, 1 green, 2 orange
//   time_left   - ticks remaining in the current phase
//   lane_switch - pulse on the first cycle of green
interface junction_phase_scheduler_if import junction_pkg::*; #(
  parameter int NUM_LANES = DEF_NUM_LANES
);

  localparam int LW = lane_w(NUM_LANES);

  logic                 tick;
  logic [NUM_LANES-1:0] traffic;
  logic [NUM_LANES-1:0] green;
  logic [NUM_LANES-1:0] orange;
  logic [NUM_LANES-1:0] red;
  logic [LW-1:0]        active_lane;
  logic [1:0]           phase;
  logic [7:0]           time_left;
  logic                 lane_switch;

  modport master (
    output tick, traffic,
    input  green, orange, red, active_lane, phase, time_left, lane_switch
  );

  modport slave (
    input  tick, traffic,
    output green, orange, red, active_lane, phase, time_left, lane_switch
  );

endinterface

// File: rtl/rr_lane_picker.sv
// Combinational round-robin search over the lane demand vector.
//   traffic       - per-lane demand
//   cur_lane      - lane holding (or last holding) the grant
//   next_lane     - first demanding lane after cur_lane, wrapping, with
//                   cur_lane itself examined last; cur_lane+1 if none demand
//   any_other_req - some lane other than cur_lane is demanding
module rr_lane_picker #(
  parameter int NUM_LANES = 4,
  parameter int LW        = 2
) (
  input  logic [NUM_LANES-1:0] traffic,
  input  logic [LW-1:0]        cur_lane,
  output logic [LW-1:0]        next_lane,
  output logic                 any_other_req
);

  always_comb begin
    logic [LW-1:0] idx;
    logic          found;
    idx           = '0;
    found         = 1'b0;
    any_other_req = 1'b0;
    next_lane     = LW'((int'(cur_lane) + 1) % NUM_LANES);
    for (int i = 1; i <= NUM_LANES; i++) begin
      idx = LW'((int'(cur_lane) + i) % NUM_LANES);
      if (!found && traffic[idx]) begin
        next_lane = idx;
        found     = 1'b1;
      end
      // The last step of the loop lands back on cur_lane itself.
      if (i < NUM_LANES && traffic[idx]) begin
        any_other_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/junction_phase_scheduler.sv
// Junction controller sharing one green right-of-way among NUM_LANES
// approaches. Each grant runs GREEN -> ORANGE -> ALL_RED, then a
// round-robin pick of the next demanding lane. Green ends early when its
// own lane empties while others wait, and is capped at MAX_GREEN while
// others wait. All timing advances only on tick cycles.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of junction_phase_scheduler_if (tick/traffic in,
//           lights, active lane, phase, time left, lane_switch out)
//
//   state      | meaning
//   PH_ALL_RED | every lane red, clearance before the next grant
//   PH_GREEN   | active_lane has right-of-way
//   PH_ORANGE  | active_lane is clearing
module junction_phase_scheduler import junction_pkg::*; #(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int AMBER_T   = DEF_AMBER_T,
  parameter int ALL_RED_T = DEF_ALL_RED_T
) (
  input  logic                       clk,
  input  logic                       rst_n,
  junction_phase_scheduler_if.slave  bus
);

  localparam int LW = lane_w(NUM_LANES);

  // Nine-bit thresholds so that sec_cnt + 1 never wraps in a compare.
  localparam logic [8:0] MIN_G9 = 9'(MIN_GREEN);
  localparam logic [8:0] MAX_G9 = 9'(MAX_GREEN);
  localparam logic [8:0] AMB_9  = 9'(AMBER_T);
  localparam logic [8:0] AR_9   = 9'(ALL_RED_T);
  localparam logic [7:0] MAX_G8 = 8'(MAX_GREEN);
  localparam logic [7:0] AMB_8  = 8'(AMBER_T);
  localparam logic [7:0] AR_8   = 8'(ALL_RED_T);
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

  logic [1:0]           phase_q, phase_d;
  logic [7:0]           sec_cnt_q, sec_cnt_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic                 sw_q, sw_d;
  logic [LW-1:0]        next_lane;
  logic                 any_other;
  logic                 own_req;
  logic [8:0]           e;
  logic [NUM_LANES-1:0] onehot;
  logic [NUM_LANES-1:0] green_w;
  logic [NUM_LANES-1:0] orange_w;
  logic [7:0]           time_left_w;

  rr_lane_picker #(
    .NUM_LANES (NUM_LANES),
    .LW        (LW)
  ) u_picker (
    .traffic       (bus.traffic),
    .cur_lane      (lane_q),
    .next_lane     (next_lane),
    .any_other_req (any_other)
  );

  assign own_req = bus.traffic[lane_q];
  assign e       = {1'b0, sec_cnt_q} + 9'd1;

  always_comb begin
    phase_d   = phase_q;
    sec_cnt_d = sec_cnt_q;
    lane_d    = lane_q;
    sw_d      = 1'b0;
    case (phase_q)
      PH_GREEN: begin
        if (bus.tick) begin
          if (e < MIN_G9) begin
            sec_cnt_d = e[7:0];
          end else if (!any_other) begin
            // Nobody else waiting: hold green, count saturates at the cap.
            sec_cnt_d = (e > MAX_G9) ? MAX_G9[7:0] : e[7:0];
          end else if (!own_req || e >= MAX_G9) begin
            phase_d   = PH_ORANGE;
            sec_cnt_d = '0;
          end else begin
            sec_cnt_d = e[7:0];
          end
        end
      end
      PH_ORANGE: begin
        if (bus.tick) begin
          if (e >= AMB_9) begin
            phase_d   = PH_ALL_RED;
            sec_cnt_d = '0;
          end else begin
            sec_cnt_d = e[7:0];
          end
        end
      end
      PH_ALL_RED: begin
        if (bus.tick) begin
          if (e >= AR_9) begin
            phase_d   = PH_GREEN;
            sec_cnt_d = '0;
            lane_d    = next_lane;
            sw_d      = 1'b1;
          end else begin
            sec_cnt_d = e[7:0];
          end
        end
      end
      default: begin
        // Unused encoding: fall back to a safe clearance interval.
        phase_d   = PH_ALL_RED;
        sec_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_ALL_RED;
      sec_cnt_q <= '0;
      lane_q    <= LAST_LANE;
      sw_q      <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      sec_cnt_q <= sec_cnt_d;
      lane_q    <= lane_d;
      sw_q      <= sw_d;
    end
  end

  always_comb begin
    onehot         = '0;
    onehot[lane_q] = 1'b1;
    green_w        = '0;
    orange_w       = '0;
    time_left_w    = '0;
    case (phase_q)
      PH_GREEN: begin
        green_w     = onehot;
        time_left_w = MAX_G8 - sec_cnt_q;
      end
      PH_ORANGE: begin
        orange_w    = onehot;
        time_left_w = AMB_8 - sec_cnt_q;
      end
      PH_ALL_RED: begin
        time_left_w = AR_8 - sec_cnt_q;
      end
      default: ;
    endcase
  end

  assign bus.green       = green_w;
  assign bus.orange      = orange_w;
  assign bus.red         = ~(green_w | orange_w);
  assign bus.active_lane = lane_q;
  assign bus.phase       = phase_q;
  assign bus.time_left   = time_left_w;
  assign bus.lane_switch = sw_q;

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Self-checking bench for junction_phase_scheduler (4 lanes, default timing).
module tb_junction_phase_scheduler;
  import junction_pkg::*;

  localparam int N = 4;

  typedef struct packed {
    logic [1:0] ph;
    logic [1:0] lane;
    logic [7:0] tl;
    logic [3:0] g;
    logic [3:0] o;
    logic [3:0] r;
    logic       sw;
  } obs_t;

  typedef struct {
    logic [3:0] tr;
    int         n;
    obs_t       exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  junction_phase_scheduler_if #(.NUM_LANES(N)) bus ();

  junction_phase_scheduler #(
    .NUM_LANES (N),
    .MIN_GREEN (10),
    .MAX_GREEN (60),
    .AMBER_T   (4),
    .ALL_RED_T (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   sw_count = 0;
  int   cyc_no   = 0;
  obs_t exp_q[$];
  vec_t vecs[$];

  int m_ph, m_sec, m_lane;
  bit m_sw;

  function automatic obs_t mk_obs(int ph, int lane, int tl, bit sw);
    obs_t o;
    o.ph   = 2'(ph);
    o.lane = 2'(lane);
    o.tl   = 8'(tl);
    o.g    = (ph == 1) ? 4'(1 << lane) : 4'b0000;
    o.o    = (ph == 2) ? 4'(1 << lane) : 4'b0000;
    o.r    = ~(o.g | o.o);
    o.sw   = sw;
    return o;
  endfunction

  function automatic vec_t mk(logic [3:0] tr, int n, int ph, int lane, int tl);
    vec_t v;
    v.tr  = tr;
    v.n   = n;
    v.exp = mk_obs(ph, lane, tl, 1'b0);
    return v;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.ph   = bus.phase;
    o.lane = bus.active_lane;
    o.tl   = bus.time_left;
    o.g    = bus.green;
    o.o    = bus.orange;
    o.r    = bus.red;
    o.sw   = bus.lane_switch;
    return o;
  endfunction

  function automatic obs_t model_obs();
    int tl;
    if (m_ph == 1)      tl = 60 - m_sec;
    else if (m_ph == 2) tl = 4 - m_sec;
    else                tl = 2 - m_sec;
    return mk_obs(m_ph, m_lane, tl, m_sw);
  endfunction

  task automatic model_reset();
    m_ph   = 0;
    m_sec  = 0;
    m_lane = 3;
    m_sw   = 1'b0;
  endtask

  task automatic model_step(input bit tk, input logic [3:0] tr);
    int  e;
    int  cand;
    bit  found;
    m_sw = 1'b0;
    if (tk) begin
      e = m_sec + 1;
      if (m_ph == 1) begin
        if (e < 10) m_sec = e;
        else if ((tr & ~4'(1 << m_lane)) == 4'b0000) m_sec = (e > 60) ? 60 : e;
        else if (tr[m_lane] == 1'b0 || e >= 60) begin m_ph = 2; m_sec = 0; end
        else m_sec = e;
      end else if (m_ph == 2) begin
        if (e >= 4) begin m_ph = 0; m_sec = 0; end
        else m_sec = e;
      end else begin
        if (e >= 2) begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            cand = (m_lane + k) % N;
            if (!found && tr[cand]) begin m_lane = cand; found = 1'b1; end
          end
          if (!found) m_lane = (m_lane + 1) % N;
          m_ph  = 1;
          m_sec = 0;
          m_sw  = 1'b1;
        end else m_sec = e;
      end
    end
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got ph=%0d lane=%0d tl=%0d g=%b o=%b r=%b sw=%b, expected ph=%0d lane=%0d tl=%0d g=%b o=%b r=%b sw=%b",
               name, act.ph, act.lane, act.tl, act.g, act.o, act.r, act.sw,
               exp.ph, exp.lane, exp.tl, exp.g, exp.o, exp.r, exp.sw);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive, predict, then compare after the edge.
  task automatic cyc(input bit tk, input logic [3:0] tr);
    obs_t e;
    bus.tick    = tk;
    bus.traffic = tr;
    model_step(tk, tr);
    exp_q.push_back(model_obs());
    @(posedge clk);
    @(negedge clk);
    cyc_no++;
    if (exp_q.size() == 0) begin
      check_int("sb_queue_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check_obs($sformatf("sb_cycle_%0d", cyc_no), dut_obs(), e);
    end
    if (bus.lane_switch) sw_count++;
  endtask

  task automatic tick_once(input logic [3:0] tr);
    cyc(1'b1, tr);
    cyc(1'b0, tr);
  endtask

  task automatic do_reset();
    bus.tick    = 1'b0;
    bus.traffic = 4'b0000;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick    = 1'b0;
    bus.traffic = 4'b0000;
    model_reset();

    // Idle junction: default rotation to lane 0, then indefinite green.
    do_reset();
    check_obs("reset_state", dut_obs(), mk_obs(0, 3, 2, 1'b0));
    sw_count = 0;
    repeat (2) tick_once(4'b0000);
    check_obs("idle_grant_lane0", dut_obs(), mk_obs(1, 0, 60, 1'b0));
    repeat (100) tick_once(4'b0000);
    check_obs("idle_green_saturates", dut_obs(), mk_obs(1, 0, 0, 1'b0));
    check_int("idle_lane_switch_count", sw_count, 1);

    // Table-driven sequencing from a fresh reset.
    vecs.push_back(mk(4'b0110,  0, 0, 3,  2));
    vecs.push_back(mk(4'b0110,  1, 0, 3,  1));
    vecs.push_back(mk(4'b0110,  1, 1, 1, 60));
    vecs.push_back(mk(4'b0110,  9, 1, 1, 51));
    vecs.push_back(mk(4'b0110, 50, 1, 1,  1));
    vecs.push_back(mk(4'b0110,  1, 2, 1,  4));
    vecs.push_back(mk(4'b0110,  3, 2, 1,  1));
    vecs.push_back(mk(4'b0110,  1, 0, 1,  2));
    vecs.push_back(mk(4'b0110,  1, 0, 1,  1));
    vecs.push_back(mk(4'b0110,  1, 1, 2, 60));
    vecs.push_back(mk(4'b1000, 10, 2, 2,  4));
    vecs.push_back(mk(4'b1000,  4, 0, 2,  2));
    vecs.push_back(mk(4'b1000,  2, 1, 3, 60));
    vecs.push_back(mk(4'b0001, 10, 2, 3,  4));
    vecs.push_back(mk(4'b0001,  4, 0, 3,  2));
    vecs.push_back(mk(4'b0001,  1, 0, 3,  1));
    vecs.push_back(mk(4'b1001,  1, 1, 0, 60));
    vecs.push_back(mk(4'b1000, 10, 2, 0,  4));
    vecs.push_back(mk(4'b1000,  6, 1, 3, 60));
    vecs.push_back(mk(4'b0001, 10, 2, 3,  4));
    vecs.push_back(mk(4'b0001,  5, 0, 3,  1));
    vecs.push_back(mk(4'b1000,  1, 1, 3, 60));
    vecs.push_back(mk(4'b1001, 24, 1, 3, 36));
    vecs.push_back(mk(4'b0001,  1, 2, 3,  4));
    vecs.push_back(mk(4'b1001,  6, 1, 0, 60));
    vecs.push_back(mk(4'b1001,  3, 1, 0, 57));
    vecs.push_back(mk(4'b1000,  6, 1, 0, 51));
    vecs.push_back(mk(4'b1000,  1, 2, 0,  4));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      for (int t = 0; t < vecs[i].n; t++) tick_once(vecs[i].tr);
      check_obs($sformatf("vec_%0d", i), dut_obs(), vecs[i].exp);
    end

    // Asynchronous reset in the middle of orange, between clock edges.
    tick_once(4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    check_obs("async_reset_no_edge", dut_obs(), mk_obs(0, 3, 2, 1'b0));
    @(negedge clk);
    check_obs("async_reset_held", dut_obs(), mk_obs(0, 3, 2, 1'b0));
    rst_n = 1'b1;
    model_reset();
    repeat (2) tick_once(4'b0100);
    check_obs("resume_after_reset", dut_obs(), mk_obs(1, 2, 60, 1'b0));

    // Random traffic and irregular tick spacing against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/junction_phase_scheduler.md
Name: junction_phase_scheduler

Overview:
- Junction-level controller that shares the single green right-of-way among NUM_LANES approaches.
- Density-aware: a green phase ends early when its lane empties and other lanes are waiting, and is capped at MAX_GREEN while others wait.
- Sequence per lane: GREEN → ORANGE → ALL_RED, then a round-robin grant to the next demanding lane.
- Sits above the per-lane light drivers and consumes the shared 1 s Tick strobe.

Parameters:
- NUM_LANES, 4: number of approaches; legal range 2..8.
- MIN_GREEN, 10: minimum green length in Ticks; 1 ≤ MIN_GREEN ≤ MAX_GREEN.
- MAX_GREEN, 60: maximum green length in Ticks while other lanes wait; ≤ 255.
- AMBER_T, 4: orange length in Ticks; 1..255.
- ALL_RED_T, 2: all-red clearance length in Ticks; 1..255.

Ports:
- Clk  input  1  system clock.
- Rst_n  input  1  asynchronous, active-low reset.
- Tick  input  1  one-cycle timing strobe, 1 per second, synchronous to Clk.
- Traffic  input  NUM_LANES  per-lane density/occupancy request, level-sensitive, synchronous to Clk.
- Green  output  NUM_LANES  one-hot green, or all zero.
- Orange  output  NUM_LANES  one-hot orange, or all zero.
- Red  output  NUM_LANES  red, which is the complement of (Green | Orange).
- Active_Lane  output  clog2(NUM_LANES)  lane currently or most recently granted.
- Phase  output  2  0 = ALL_RED, 1 = GREEN, 2 = ORANGE.
- Time_Left  output  8  Ticks remaining in the current phase, for display.
- Lane_Switch  output  1  one-cycle pulse on the cycle GREEN is entered.

Behaviour:
- Interface: one clock (Clk); reset is asynchronous and active-low (Rst_n).
- Reset state:
  - Phase = ALL_RED, sec_cnt = 0, Active_Lane = NUM_LANES-1.
  - Red = all ones; Green = Orange = 0; Lane_Switch = 0; Time_Left = ALL_RED_T.
- Reset mid-operation forces the reset state immediately, without waiting for a clock edge.
- All outputs are Moore outputs, decoded only from registers. Traffic and Tick have no combinational path to any output.
- sec_cnt (8 bit) counts Ticks elapsed in the current phase. It clears to 0 on every phase change.
- State only advances on cycles where Tick = 1. Let e = sec_cnt + 1, evaluated on the Tick cycle.
- GREEN:
  - If e < MIN_GREEN: stay; sec_cnt ← e.
  - Else if no other lane requests (Traffic & ~onehot(Active_Lane) == 0): stay; sec_cnt ← min(e, MAX_GREEN). Green holds indefinitely.
  - Else if Traffic[Active_Lane] = 0 or e ≥ MAX_GREEN: go to ORANGE.
  - Else: stay; sec_cnt ← e.
- ORANGE: when e ≥ AMBER_T, go to ALL_RED.
- ALL_RED: when e ≥ ALL_RED_T, go to GREEN.
  - Active_Lane ← the first lane with Traffic = 1, searching cyclically from Active_Lane+1 and wrapping modulo NUM_LANES, with Active_Lane itself examined last.
  - If no lane requests, Active_Lane ← (Active_Lane+1) mod NUM_LANES.
  - Traffic is sampled on the transition cycle itself.
  - Lane_Switch = 1 for exactly the first cycle of GREEN.
- Time_Left:
  - GREEN: MAX_GREEN − sec_cnt.
  - ORANGE: AMBER_T − sec_cnt.
  - ALL_RED: ALL_RED_T − sec_cnt.
- Traffic changes on a non-Tick cycle have no effect until the next Tick.
- Tick held high for k cycles counts as k Ticks. This is a legal but undefined use.
- Green and Orange are never both set. At most one lane is non-red at any time.
- Phase encoding 3 is illegal. If reached, it recovers to ALL_RED with sec_cnt = 0 on the next clock edge.

Decomposition:
- Package junction_pkg holds:
  - the phase encodings PH_ALL_RED, PH_GREEN, PH_ORANGE;
  - default timing constants;
  - a function that computes the lane-index width from NUM_LANES.
- Sub-module rr_lane_picker: a combinational round-robin search.
  - Inputs: Traffic, current lane.
  - Outputs: next lane, any_other_req.
  - It is instantiated once.

Test Plan:
1. Rst_n low, then high with Traffic = 0000 → all Red for 2 Ticks; Green[0] = 1, Active_Lane = 0, Lane_Switch pulses once; green then holds for 100 further Ticks with Time_Left saturating at 0.
2. Reset, then Traffic = 0110 constant → lane 1 green after 2 Ticks, holds 60 Ticks; Orange[1] for 4 Ticks, all-red for 2, then Green[2].
3. Lane 1 green with 0110, Traffic[1] dropped at green Tick 3 → Orange[1] asserted on green Tick 10 (MIN_GREEN), not earlier.
4. Lane 1 green with 0110, Traffic[1] dropped between Tick 24 and 25 → Orange[1] on Tick 25.
5. Active_Lane = 3, Traffic = 1001 at the end of ALL_RED → lane 0 granted, not lane 3; with Traffic = 1000, lane 3 is re-granted.
6. Rst_n pulsed low mid-ORANGE between clock edges → Red = 1111, Phase = 0, Active_Lane = 3 immediately, with no clock edge required; normal sequencing resumes after release.
